pipe_stage_reg: RTL

- Generic parametrised pipeline stage register: the successor to the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Payload is one packed bus of DATA_W bits.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered.
- Supports flush, kill (invalid instruction turned into a bubble), and a configurable NOP encoding for bubbles.
- Sits between any two pipeline stages; the core instantiates it once per stage boundary.

---
 rtl/pipe_stage_reg.sv | 93 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with a 2-entry skid buffer.
// The upstream ready is fully registered. Kill turns a beat into a bubble.
// Bubbles carry NOP_VALUE.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   flush            drop all held entries and the current upstream beat
//   up_valid/up_kill/up_data/up_ready   upstream handshake; up_ready is registered
//   dn_valid/dn_data/dn_ready           downstream handshake; dn_data is registered
//   occupancy        number of held entries, 0..2
//   perf_clr, perf_bubble_cnt, perf_stall_cnt   optional counters
// Macro PIPE_STAGE_PERF_EN enables the saturating bubble and stall counters.
// When the macro is undefined, both counter outputs are 0.
module pipe_stage_reg #(
   parameter int                DATA_W    = 112,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int                PERF_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              up_valid,
   input  logic              up_kill,
   input  logic [DATA_W-1:0] up_data,
   output logic              up_ready,
   output logic              dn_valid,
   output logic [DATA_W-1:0] dn_data,
   input  logic              dn_ready,
   output logic [1:0]        occupancy,
   input  logic              perf_clr,
   output logic [PERF_W-1:0] perf_bubble_cnt,
   output logic [PERF_W-1:0] perf_stall_cnt
);
   logic              m_valid, s_valid;
   logic [DATA_W-1:0] m_data, s_data;
   logic              store, m_free;
   // Upstream ready depends only on the skid flop, so it is registered.
   assign up_ready  = ~s_valid;
   assign store     = up_valid & up_ready & ~up_kill;
   assign m_free    = ~m_valid | dn_ready;
   assign dn_valid  = m_valid;
   assign dn_data   = m_data;
   assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_data  <= NOP_VALUE;
         s_data  <= NOP_VALUE;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_data  <= NOP_VALUE;
         s_data  <= NOP_VALUE;
      end else if (m_free) begin
         if (s_valid) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            s_valid <= 1'b0;
            s_data  <= NOP_VALUE;
         end else if (store) begin
            m_valid <= 1'b1;
            m_data  <= up_data;
         end else begin
            m_valid <= 1'b0;
            m_data  <= NOP_VALUE;
         end
      end else if (store) begin
         s_valid <= 1'b1;
         s_data  <= up_data;
      end
   end
`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_bubble_cnt <= '0;
         perf_stall_cnt  <= '0;
      end else if (perf_clr) begin
         perf_bubble_cnt <= '0;
         perf_stall_cnt  <= '0;
      end else begin
         if (!m_valid && perf_bubble_cnt != '1)
            perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
         if (m_valid && !dn_ready && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
   end
`else
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;
   assign perf_bubble_cnt = '0;
   assign perf_stall_cnt  = '0;
`endif
endmodule
